// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial front end for the sequence-detect path. DATA_W-bit words
//   arrive on a valid/ready handshake, wait in a 1-entry pending buffer and are
//   shifted out one bit per clock on `a`. The pending buffer lets the next word
//   load on the same edge the current word finishes, so back-to-back words
//   stream with no idle gap.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   din        in   DATA_W-bit word to serialize
//   din_valid  in   din is valid this cycle
//   din_ready  out  block can accept din this cycle (combinational)
//   a          out  serial bit stream (registered), IDLE_LVL when idle
//   a_vld      out  `a` carries a data bit this cycle (registered)
//   busy       out  pending buffer or shifter holds data
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int   DATA_W    = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              a,
  output logic              a_vld,
  output logic              busy
);

  localparam int             CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              a_q, a_d;
  logic              a_vld_q, a_vld_d;

  logic              load_now_s;
  logic              accept_s;
  logic              last_bit_s;

  // Bit that leaves the word first (head of the shift order).
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  // Word with the head bit removed, so the next bit becomes the head.
  function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign last_bit_s = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_now_s = pend_vld_q && ((state_q == IDLE) || last_bit_s);
  // The pending slot frees on a load edge, so a new word can enter on that edge.
  assign din_ready  = !pend_vld_q || load_now_s;
  assign accept_s   = din_valid && din_ready;

  // Next-state logic: pending buffer, shifter FSM, bit counter and serial output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    a_d        = a_q;
    a_vld_d    = a_vld_q;

    // Acceptance wins over draining so a same-edge accept keeps the slot full.
    if (accept_s) begin
      pend_d     = din;
      pend_vld_d = 1'b1;
    end else if (load_now_s) begin
      pend_vld_d = 1'b0;
    end else begin
      pend_vld_d = pend_vld_q;
    end

    case (state_q)
      IDLE: begin
        if (load_now_s) begin
          state_d = SHIFT;
          a_d     = head_bit(pend_q);
          shreg_d = drop_head(pend_q);
          a_vld_d = 1'b1;
          cnt_d   = '0;
        end else begin
          a_d     = IDLE_LVL;
          a_vld_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          a_d     = head_bit(shreg_q);
          shreg_d = drop_head(shreg_q);
          cnt_d   = cnt_q + CNT_W'(1);
          a_vld_d = 1'b1;
        end else if (pend_vld_q) begin
          // Seamless reload: next word's first bit follows the last bit directly.
          a_d     = head_bit(pend_q);
          shreg_d = drop_head(pend_q);
          a_vld_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          a_d     = IDLE_LVL;
          a_vld_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        a_d     = IDLE_LVL;
        a_vld_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards both pending and shifting words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      a_q        <= IDLE_LVL;
      a_vld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      a_q        <= a_d;
      a_vld_q    <= a_vld_d;
    end
  end

  assign a     = a_q;
  assign a_vld = a_vld_q;
  assign busy  = pend_vld_q || (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Directed bench for bit_serializer. Two instances share clock, reset and
//   input: `dut` is MSB-first, `dut_l` is LSB-first. A table of single-word
//   vectors is replayed in a loop; streaming, backpressure, mid-word reset and
//   idle-gap behaviour are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, a, a_vld, busy;
  logic       din_ready_l, a_l, a_vld_l, busy_l;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .a(a), .a_vld(a_vld), .busy(busy)
  );

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .a(a_l), .a_vld(a_vld_l), .busy(busy_l)
  );

  typedef struct {
    logic [7:0] word;
    bit         lsb;      // 1: observe the LSB-first instance
    logic [7:0] exp_seq;  // expected stream, bit 7 = first bit on the wire
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the selected instance idle; returns at a negedge
  // one cycle after the last data bit, having checked that idle cycle.
  task automatic send_word(input logic [7:0] w, input bit lsb, input logic [7:0] exp_seq);
    chk("ready_before_send", {31'd0, (lsb ? din_ready_l : din_ready)}, 32'd1);
    din       = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    @(negedge clk);
    chk("latency_vld_low", {31'd0, (lsb ? a_vld_l : a_vld)}, 32'd0);
    chk("busy_pending", {31'd0, (lsb ? busy_l : busy)}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bit%0d_a", i), {31'd0, (lsb ? a_l : a)}, {31'd0, exp_seq[7-i]});
      chk($sformatf("bit%0d_vld", i), {31'd0, (lsb ? a_vld_l : a_vld)}, 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("end_a_idle", {31'd0, (lsb ? a_l : a)}, 32'd1);
    chk("end_vld_low", {31'd0, (lsb ? a_vld_l : a_vld)}, 32'd0);
  endtask

  // Watchdog: every sequence is bounded, this only guards against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] got;
    int nbits, first_cyc, last_cyc, cyc, ready_low, widx, vld_seen;
    logic [7:0] words[3];
    bit hs;

    vecs[0] = '{word: 8'h71, lsb: 1'b0, exp_seq: 8'b0111_0001};
    vecs[1] = '{word: 8'h8E, lsb: 1'b1, exp_seq: 8'b0111_0001};
    vecs[2] = '{word: 8'hA5, lsb: 1'b0, exp_seq: 8'b1010_0101};
    vecs[3] = '{word: 8'h01, lsb: 1'b1, exp_seq: 8'b1000_0000};
    vecs[4] = '{word: 8'h00, lsb: 1'b0, exp_seq: 8'b0000_0000};
    vecs[5] = '{word: 8'hC3, lsb: 1'b1, exp_seq: 8'b1100_0011};

    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_a", {31'd0, a}, 32'd1);
    chk("rst_a_vld", {31'd0, a_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_din_ready", {31'd0, din_ready}, 32'd1);

    // Single-word vectors (includes 8'h71 MSB-first and 8'h8E LSB-first)
    foreach (vecs[v]) begin
      send_word(vecs[v].word, vecs[v].lsb, vecs[v].exp_seq);
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Continuous streaming A5,3C,FF with backpressure on the third word
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    widx = 0; nbits = 0; ready_low = 0; first_cyc = -1; last_cyc = -1; got = '0;
    vld_seen = 0;
    din = words[0];
    din_valid = 1'b1;
    for (cyc = 0; cyc < 60 && !(nbits == 24 && !a_vld); cyc++) begin
      hs = din_valid && din_ready;
      if (din_valid && !din_ready) ready_low++;
      @(posedge clk);
      #1;
      if (hs) begin
        widx++;
        if (widx < 3) din = words[widx];
        else din_valid = 1'b0;
      end
      @(negedge clk);
      if (a_vld) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got = {got[22:0], a};
        nbits++;
        vld_seen++;
      end
    end
    chk("stream_done_in_budget", {31'd0, (nbits == 24 && !a_vld)}, 32'd1);
    chk("stream_bits", {8'd0, got}, 32'hA53CFF);
    chk("stream_nbits", nbits, 32'd24);
    chk("stream_contiguous", last_cyc - first_cyc + 1, 32'd24);
    chk("stream_ready_low_cycles", ready_low, 32'd7);
    chk("stream_words_taken", widx, 32'd3);
    chk("stream_idle_a", {31'd0, a}, 32'd1);

    // Reset mid-word after bit 3 of 8'h71
    @(negedge clk);
    din = 8'h71;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_mid_bit3", {30'd0, a, a_vld}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_a", {31'd0, a}, 32'd1);
    chk("rst_mid_a_vld", {31'd0, a_vld}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, din_ready_l}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_vld || busy) vld_seen++;
    end
    chk("rst_no_residual", vld_seen, 32'd0);

    // Idle gap: 8'h0F, five idle cycles, then 8'hF0
    send_word(8'h0F, 1'b0, 8'b0000_1111);
    for (int g = 2; g <= 4; g++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("gap%0d", g), {30'd0, a, a_vld}, 32'd2);
    end
    send_word(8'hF0, 1'b0, 8'b1111_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
